// File: rtl/dso100fb_ahb_sram_if.sv
// AHB-Lite bus bundle between the framebuffer fetch master (or a CPU/test
// master) and the dso100fb on-chip SRAM responder.
interface dso100fb_ahb_sram_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/dso100fb_ahb_sram.sv
// dso100fb_ahb_sram: AHB-Lite slave backed by a single-port word memory.
// Serves the framebuffer fetch bursts and CPU/test writes, with a fixed
// number of wait states per OKAY data phase and two-cycle ERROR responses.
// Writes are posted one cycle; reads forward pending write bytes.
// Optional macro DSO100FB_AHB_SRAM_WRPROT_EN adds a WR_PROTECT input that
// turns every write into an ERROR access while asserted.
module dso100fb_ahb_sram #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic CLK,
  input logic RST,
`ifdef DSO100FB_AHB_SRAM_WRPROT_EN
  input logic WR_PROTECT,
`endif
  dso100fb_ahb_sram_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic [31:0] mem [DEPTH];

  // address-phase decode
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  phase_free;
  logic                  take;
  logic                  size_bad;
  logic                  misalign;
  logic                  range_bad;
  logic                  prot_bad;
  logic                  illegal;
  logic [3:0]            lane_mask;

  // registered data-phase attributes of the accepted OKAY access
  logic                  dp_write_q;
  logic [ADDR_WIDTH-1:0] dp_addr_q;
  logic [3:0]            dp_mask_q;
  logic                  complete_wr;

  // posted write
  logic                  pend_valid_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [3:0]            pend_mask_q;
  logic [31:0]           pend_data_q;

  // read path
  logic                  rd_take;
  logic [31:0]           ram_q;
  logic [3:0]            fwd_mask_d, fwd_mask_q;
  logic [31:0]           fwd_data_d, fwd_data_q;

  logic unused_inputs;
  assign unused_inputs = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  // Decode the address phase and classify it as OKAY or ERROR.
  always_comb begin
    offset     = bus.HADDR - BASE_ADDR;
    word_addr  = offset[ADDR_WIDTH+1:2];
    phase_free = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    take       = bus.HSEL && bus.HREADY && bus.HTRANS[1] && phase_free;
    size_bad   = bus.HSIZE > 3'd2;
    misalign   = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                 ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    range_bad  = (offset >> (ADDR_WIDTH + 2)) != 32'd0;
`ifdef DSO100FB_AHB_SRAM_WRPROT_EN
    prot_bad   = bus.HWRITE && WR_PROTECT;
`else
    prot_bad   = 1'b0;
`endif
    illegal    = size_bad || misalign || range_bad || prot_bad;
    case (bus.HSIZE)
      3'd0:    lane_mask = 4'b0001 << bus.HADDR[1:0];
      3'd1:    lane_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Response state and wait counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next response state and the HREADYOUT/HRESP it implies.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (take) begin
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            wait_d  = 4'(WAIT_STATES);
          end
        end else begin
          state_d = S_IDLE;
        end
        bus.HRESP = (state_q == S_ERR2);
      end
      S_WAIT: begin
        bus.HREADYOUT = 1'b0;
        wait_d        = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = S_DATA;
        end
      end
      S_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
        state_d       = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Remember direction, word and lanes of an accepted OKAY access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_mask_q  <= '0;
    end else if (take && !illegal) begin
      dp_write_q <= bus.HWRITE;
      dp_addr_q  <= word_addr;
      dp_mask_q  <= lane_mask;
    end
  end

  assign complete_wr = (state_q == S_DATA) && dp_write_q;
  assign rd_take     = take && !illegal && !bus.HWRITE;

  // Capture write data at the end of its data phase; it is committed next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_mask_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= complete_wr;
      if (complete_wr) begin
        pend_addr_q <= dp_addr_q;
        pend_mask_q <= dp_mask_q;
        pend_data_q <= bus.HWDATA;
      end
    end
  end

  // Commit the posted write byte-wise; a reset edge drops it.
  always_ff @(posedge CLK) begin
    if (!RST && pend_valid_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (pend_mask_q[b]) begin
          mem[pend_addr_q][8*b +: 8] <= pend_data_q[8*b +: 8];
        end
      end
    end
  end

  // The RAM is read-old at the accept edge, so both the write committing on
  // that edge and the write whose data phase ends on it are overlaid here.
  always_comb begin
    fwd_mask_d = '0;
    fwd_data_d = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (pend_valid_q && (pend_addr_q == word_addr) && pend_mask_q[b]) begin
        fwd_mask_d[b]          = 1'b1;
        fwd_data_d[8*b +: 8]   = pend_data_q[8*b +: 8];
      end
      if (complete_wr && (dp_addr_q == word_addr) && dp_mask_q[b]) begin
        fwd_mask_d[b]          = 1'b1;
        fwd_data_d[8*b +: 8]   = bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Synchronous RAM read plus forwarding snapshot, updated only by OKAY reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_q      <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else if (rd_take) begin
      ram_q      <= mem[word_addr];
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Merge RAM word with forwarded lanes; stays put until the next read.
  always_comb begin
    bus.HRDATA = ram_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (fwd_mask_q[b]) begin
        bus.HRDATA[8*b +: 8] = fwd_data_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dso100fb_ahb_sram.sv
// Bench for dso100fb_ahb_sram: three instances (0, 2 and 3 wait states)
// share one master; a transaction-level model predicts HREADYOUT, HRESP
// and HRDATA for every instance on every cycle, and directed transfers are
// pinned with hand-computed literals.
module tb_dso100fb_ahb_sram;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        hsel   = 1'b0;
  logic [31:0] haddr  = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize  = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  int          sel    = 0;
`ifdef DSO100FB_AHB_SRAM_WRPROT_EN
  logic        wr_protect = 1'b0;
`endif

  logic        rdy   [3];
  logic        resp  [3];
  logic [31:0] rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    dso100fb_ahb_sram_if bus ();
    assign bus.HSEL      = hsel && (sel == g);
    assign bus.HADDR     = haddr;
    assign bus.HTRANS    = htrans;
    assign bus.HWRITE    = hwrite;
    assign bus.HSIZE     = hsize;
    assign bus.HBURST    = hburst;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata;
    assign bus.HREADY    = bus.HREADYOUT;
    assign rdy[g]        = bus.HREADYOUT;
    assign resp[g]       = bus.HRESP;
    assign rdata[g]      = bus.HRDATA;
    dso100fb_ahb_sram #(
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(WS)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
`ifdef DSO100FB_AHB_SRAM_WRPROT_EN
      .WR_PROTECT(wr_protect),
`endif
      .bus       (bus)
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  logic [31:0] mdl_mem [3][DEPTH];
  int          ph      [3];   // 0 no data phase, 1 OKAY phase, 2 ERROR phase
  int          low     [3];   // stall cycles still owed by the OKAY phase
  int          estep   [3];   // 0 first ERROR cycle, 1 second
  logic        pw      [3];
  logic [31:0] paddr   [3];
  logic [2:0]  psize   [3];
  logic [31:0] exp_rd  [3];
  logic        model_on = 1'b0;

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz,
                               input logic wr, input logic prot);
    logic [31:0] off;
    off = a - BASE;
    if (sz > 3'd2) return 1'b0;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b0;
    if (off >= 32'(4 * DEPTH)) return 1'b0;
    if (wr && prot) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic prot_now();
`ifdef DSO100FB_AHB_SRAM_WRPROT_EN
    return wr_protect;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wr_model(input int k);
    int w, lo, n;
    w  = int'((paddr[k] - BASE) >> 2);
    lo = int'(paddr[k][1:0]);
    n  = 1 << psize[k];
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + n) mdl_mem[k][w][8*b +: 8] = hwdata[8*b +: 8];
  endtask

  // compare at negedge, advance the model at posedge
  always begin
    @(negedge clk);
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        logic er;
        er = (ph[k] == 0) ? 1'b1 : (ph[k] == 1) ? (low[k] == 0) : (estep[k] == 1);
        chk($sformatf("hreadyout[%0d]", k), {31'b0, rdy[k]}, {31'b0, er});
        chk($sformatf("hresp[%0d]", k), {31'b0, resp[k]}, {31'b0, ph[k] == 2});
        chk($sformatf("hrdata[%0d]", k), rdata[k], exp_rd[k]);
      end
    end
    @(posedge clk);
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        bit free;
        free = 1'b0;
        if (rst) begin
          ph[k]     = 0;
          exp_rd[k] = '0;
        end else begin
          if (ph[k] == 0) begin
            free = 1'b1;
          end else if (ph[k] == 1) begin
            if (low[k] == 0) begin
              if (pw[k]) wr_model(k);
              ph[k] = 0;
              free  = 1'b1;
            end else begin
              low[k]--;
            end
          end else begin
            if (estep[k] == 1) begin
              ph[k] = 0;
              free  = 1'b1;
            end else begin
              estep[k] = 1;
            end
          end
          if (free && hsel && (sel == k) && htrans[1]) begin
            if (legal(haddr, hsize, hwrite, prot_now())) begin
              ph[k]    = 1;
              low[k]   = ws_of(k);
              pw[k]    = hwrite;
              paddr[k] = haddr;
              psize[k] = hsize;
              if (!hwrite) exp_rd[k] = mdl_mem[k][int'((haddr - BASE) >> 2)];
            end else begin
              ph[k]    = 2;
              estep[k] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- pipelined master ----------------
  int          nops;
  logic [31:0] op_addr  [16];
  logic        op_wr    [16];
  logic [2:0]  op_size  [16];
  logic [31:0] op_wdata [16];
  logic [31:0] res_rdata[16];
  logic        res_resp [16];
  int          res_lows [16];

  task automatic clear();
    nops = 0;
  endtask

  task automatic add(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                     input logic [31:0] wd);
    op_addr[nops]  = a;
    op_wr[nops]    = wr;
    op_size[nops]  = sz;
    op_wdata[nops] = wd;
    nops++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last data phase.
  task automatic run(input int k, input logic [2:0] burst);
    sel = k;
    for (int i = 0; i <= nops; i++) begin
      logic r, rs;
      logic [31:0] d;
      int lows;
      bit done;
      lows = 0;
      done = 1'b0;
      if (i < nops) begin
        hsel   = 1'b1;
        haddr  = op_addr[i];
        hwrite = op_wr[i];
        hsize  = op_size[i];
        hburst = burst;
        htrans = (i > 0 && burst != 3'd0) ? 2'b11 : 2'b10;
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
      end
      hwdata = (i > 0 && op_wr[i-1]) ? op_wdata[i-1] : 32'h0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        r  = rdy[k];
        rs = resp[k];
        d  = rdata[k];
        if (!r) lows++;
        @(posedge clk);
        #1;
        if (r) done = 1'b1;
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL timeout: dut %0d op %0d never saw HREADYOUT=1", k, i);
      end
      if (i > 0) begin
        res_rdata[i-1] = d;
        res_resp[i-1]  = rs;
        res_lows[i-1]  = lows;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      ph[k] = 0; low[k] = 0; estep[k] = 0; pw[k] = 1'b0;
      paddr[k] = '0; psize[k] = '0; exp_rd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
    chk("reset_hrdata", rdata[0], 32'h0);
    chk("reset_hreadyout", {31'b0, rdy[0]}, 32'h1);
    @(posedge clk);
    #1;

    // write then immediate read, zero wait states
    clear();
    add(BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    add(BASE + 32'h10, 1'b0, 3'd2, 32'h0);
    run(0, 3'd0);
    chk("t1_wr_stall", 32'(res_lows[0]), 32'd0);
    chk("t1_rd_stall", 32'(res_lows[1]), 32'd0);
    chk("t1_rd_data", res_rdata[1], 32'hDEADBEEF);
    chk("t1_rd_resp", {31'b0, res_resp[1]}, 32'd0);

    // INCR8 preload and readback with two wait states
    clear();
    for (int i = 0; i < 8; i++) add(BASE + 32'(4 * i), 1'b1, 3'd2, 32'h100 + 32'(i));
    run(1, 3'b101);
    clear();
    for (int i = 0; i < 8; i++) add(BASE + 32'(4 * i), 1'b0, 3'd2, 32'h0);
    run(1, 3'b101);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_stall_%0d", i), 32'(res_lows[i]), 32'd2);
      chk($sformatf("t2_data_%0d", i), res_rdata[i], 32'h100 + 32'(i));
      chk($sformatf("t2_resp_%0d", i), {31'b0, res_resp[i]}, 32'd0);
    end

    // sub-word writes and forwarding of both queued writes
    clear();
    add(BASE + 32'h4, 1'b1, 3'd2, 32'h11223344);
    add(BASE + 32'h6, 1'b1, 3'd0, 32'h00AA0000);
    add(BASE + 32'h4, 1'b0, 3'd2, 32'h0);
    add(BASE + 32'h4, 1'b1, 3'd1, 32'h0000BEEF);
    add(BASE + 32'h4, 1'b0, 3'd2, 32'h0);
    run(0, 3'd0);
    chk("t3_byte_merge", res_rdata[2], 32'h11AA3344);
    chk("t3_half_merge", res_rdata[4], 32'h11AABEEF);

    // illegal accesses: out of range, misaligned, oversize, below base
    clear(); add(BASE + 32'h100, 1'b0, 3'd2, 32'h0); run(0, 3'd0);
    chk("t4_range_stall", 32'(res_lows[0]), 32'd1);
    chk("t4_range_resp", {31'b0, res_resp[0]}, 32'd1);
    clear(); add(BASE + 32'h1, 1'b0, 3'd1, 32'h0); run(0, 3'd0);
    chk("t4_misalign_stall", 32'(res_lows[0]), 32'd1);
    chk("t4_misalign_resp", {31'b0, res_resp[0]}, 32'd1);
    clear(); add(BASE + 32'h10, 1'b1, 3'd3, 32'hFFFFFFFF); run(0, 3'd0);
    chk("t4_size_resp", {31'b0, res_resp[0]}, 32'd1);
    clear(); add(BASE - 32'h4, 1'b1, 3'd2, 32'hFFFFFFFF); run(0, 3'd0);
    chk("t4_below_resp", {31'b0, res_resp[0]}, 32'd1);
    clear();
    add(BASE + 32'h10, 1'b0, 3'd2, 32'h0);
    add(BASE + 32'h4, 1'b0, 3'd2, 32'h0);
    run(0, 3'd0);
    chk("t4_unchanged_10", res_rdata[0], 32'hDEADBEEF);
    chk("t4_unchanged_04", res_rdata[1], 32'h11AABEEF);

    // reset during the wait states of a write
    clear(); add(BASE + 32'h20, 1'b1, 3'd2, 32'h12345678); run(2, 3'd0);
    sel = 2; hsel = 1'b1; haddr = BASE + 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D; rst = 1'b1;
    @(negedge clk);
    chk("t5_in_wait", {31'b0, rdy[2]}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", {31'b0, rdy[2]}, 32'd1);
    chk("t5_rst_resp", {31'b0, resp[2]}, 32'd0);
    chk("t5_rst_hrdata", rdata[2], 32'h0);
    @(posedge clk);
    #1;
    clear(); add(BASE + 32'h20, 1'b0, 3'd2, 32'h0); run(2, 3'd0);
    chk("t5_old_value", res_rdata[0], 32'h12345678);
    chk("t5_read_stall", 32'(res_lows[0]), 32'd3);

`ifdef DSO100FB_AHB_SRAM_WRPROT_EN
    wr_protect = 1'b0;
    clear(); add(BASE + 32'h30, 1'b1, 3'd2, 32'h0F0F0F0F); run(0, 3'd0);
    wr_protect = 1'b1;
    clear();
    add(BASE + 32'h30, 1'b1, 3'd2, 32'h5555AAAA);
    run(0, 3'd0);
    chk("t6_prot_resp", {31'b0, res_resp[0]}, 32'd1);
    clear(); add(BASE + 32'h30, 1'b0, 3'd2, 32'h0); run(0, 3'd0);
    chk("t6_prot_unchanged", res_rdata[0], 32'h0F0F0F0F);
    wr_protect = 1'b0;
    clear();
    add(BASE + 32'h30, 1'b1, 3'd2, 32'h5555AAAA);
    add(BASE + 32'h30, 1'b0, 3'd2, 32'h0);
    run(0, 3'd0);
    chk("t6_unprot_resp", {31'b0, res_resp[0]}, 32'd0);
    chk("t6_unprot_data", res_rdata[1], 32'h5555AAAA);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
